// File: rtl/ifra_pkg.sv
// ifra_pkg: shared types and constants for the ifra receive path.
//   IFRA_DATA_W     : ifra byte width
//   IFRA_LFSR_SEED  : reset value of the optional ack-delay LFSR
//   ifra_rcv_st_e   : receiver handshake FSM states
//   ifra_lfsr_next  : one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package ifra_pkg;

    localparam int unsigned IFRA_DATA_W    = 8;
    localparam logic [7:0]  IFRA_LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } ifra_rcv_st_e;

    // Shift toward the MSB; the new LSB is the XOR of taps 8,6,5,4 (bits 7,5,4,3).
    function automatic logic [7:0] ifra_lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/ifra_rcv_if.sv
// ifra_rcv_if: ifra req/ack byte bus.
//   req : transmitter request, held high with din stable until ack is seen
//   din : transmitter data byte
//   ack : one-cycle acknowledge from the receiver
// Modports: master = transmitter side, slave = receiver side.
interface ifra_rcv_if;
    import ifra_pkg::*;

    logic                   req;
    logic [IFRA_DATA_W-1:0] din;
    logic                   ack;

    modport master (
        output req,
        output din,
        input  ack
    );

    modport slave (
        input  req,
        input  din,
        output ack
    );

endinterface

// File: rtl/ifra_sync_fifo.sv
// ifra_sync_fifo: single-clock show-ahead FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write strobe and data; ignored when full
//   pop/dout : read strobe and head data; pop ignored when empty, dout is 0 when empty
//   empty, full, level : status and occupancy
// Pointers carry one extra MSB so full and empty are distinguishable.
module ifra_sync_fifo
    import ifra_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = IFRA_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level   = wr_ptr_q - rd_ptr_q;
        push_en = push && !full;
        pop_en  = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Forced to zero when empty so the head reads as 0 out of reset.
    always_comb begin
        dout = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/ifra_rcv.sv
// ifra_rcv: responder (receive end) of the ifra req/ack byte interface.
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active-high
//   bus      : ifra_rcv_if.slave (req/din in, ack out)
//   ack_dly  : extra cycles before ack, sampled when a beat starts
//   rd_valid : FIFO not empty
//   rd_ready : downstream pop request
//   rd_data  : FIFO head byte (show-ahead)
//   level    : FIFO occupancy
// Each accepted byte goes into an internal FIFO. Ack latency is 1+dly cycles
// after req is first sampled in IDLE.
// Build option IFRA_RCV_RAND_DLY_EN: per-beat delay becomes
// min(lfsr[DLY_W-1:0], ack_dly) from an 8-bit LFSR seeded on reset
// (requires DLY_W <= 8). Without it the delay is ack_dly exactly.
module ifra_rcv
    import ifra_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DLY_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ifra_rcv_if.slave              bus,
    input  logic [DLY_W-1:0]       ack_dly,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [IFRA_DATA_W-1:0] rd_data,
    output logic [$clog2(DEPTH):0] level
);

    ifra_rcv_st_e     state_q;
    ifra_rcv_st_e     state_d;
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;
    logic             ack_q;
    logic [DLY_W-1:0] dly;
    logic             push;
    logic             fifo_empty;
    logic             fifo_full;

    // ---------------------------------------------------------------------
    // Per-beat delay source
    // ---------------------------------------------------------------------
`ifdef IFRA_RCV_RAND_DLY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= IFRA_LFSR_SEED;
        end else begin
            lfsr_q <= ifra_lfsr_next(lfsr_q);
        end
    end

    // ack_dly acts as the ceiling on the pseudo-random delay.
    always_comb begin
        dly = (lfsr_q[DLY_W-1:0] < ack_dly) ? lfsr_q[DLY_W-1:0] : ack_dly;
    end
`else
    always_comb begin
        dly = ack_dly;
    end
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Registered copy of "in ACK" so ack comes straight off a flop.
            ack_q   <= (state_d == ACK);
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // Only this block writes the FIFO, so checking full here
                // guarantees the later push always has room.
                if (bus.req && !fifo_full) begin
                    cnt_d   = dly;
                    state_d = (dly == '0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!bus.req) begin
                    // Transmitter withdrew the request: drop the beat.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DLY_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // The beat completes on the edge that ends the ACK cycle.
        push     = ack_q;
        rd_valid = !fifo_empty;
    end

    assign bus.ack = ack_q;

    // ---------------------------------------------------------------------
    // Receive FIFO
    // ---------------------------------------------------------------------
    ifra_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IFRA_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.din),
        .pop   (rd_ready),
        .dout  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_ifra_rcv.sv
// tb_ifra_rcv: directed self-checking bench for ifra_rcv.
// Acts as the ifra transmitter, records every popped byte and compares the
// pop stream against the bytes that were acknowledged.
module tb_ifra_rcv;
    import ifra_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DLY_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DLY_W-1:0]       ack_dly;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [IFRA_DATA_W-1:0] rd_data;
    logic [$clog2(DEPTH):0] level;

    ifra_rcv_if bus ();

    ifra_rcv #(
        .DEPTH (DEPTH),
        .DLY_W (DLY_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .ack_dly  (ack_dly),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .level    (level)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    int         chk_idx = 0;
    logic [7:0] popq[$];
    logic [7:0] expq[$];

    always @(posedge clk) cyc++;

    // Sampled mid-cycle: inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack) ack_cnt++;
            if (rd_valid && rd_ready) popq.push_back(rd_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = 1'b0;
        rd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_beat(input logic [7:0] b);
        bus.req = 1'b1;
        bus.din = b;
    endtask

    // lat = cycles from driving req until ack is seen, -1 on timeout (req left high).
    task automatic wait_ack(input int max_wait, input bit pop_on_ack, output int lat,
                            output int at);
        lat = -1;
        at  = 0;
        for (int i = 1; i <= max_wait; i++) begin
            step();
            if (bus.ack) begin
                lat = i;
                at  = cyc;
                break;
            end
        end
        if (lat < 0) return;
        expq.push_back(bus.din);
        if (pop_on_ack) rd_ready = 1'b1;
        step();
        if (pop_on_ack) rd_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        rd_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (!rd_valid) break;
            step();
        end
        rd_ready = 1'b0;
        check({tag, "_drain_lvl"}, level, 0);
        check({tag, "_n_pop"}, popq.size(), expq.size());
        for (int i = chk_idx; i < popq.size() && i < expq.size(); i++) begin
            check({tag, "_pop_data"}, popq[i], expq[i]);
        end
        chk_idx = popq.size();
    endtask

    int lat;
    int at;
    int prev_at;
    int c0;
    int bad;
`ifdef IFRA_RCV_RAND_DLY_EN
    int lat1[4];
    int lat2[4];
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bus.req  = 1'b0;
        bus.din  = '0;
        ack_dly  = '0;
        rd_ready = 1'b0;
        rst      = 1'b1;
        do_reset();

        // Reset state
        check("rst_ack", bus.ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_rd_data", rd_data, 0);

        // T1: zero delay, back-to-back beats, period 2
        ack_dly  = 0;
        rd_ready = 1'b1;
        prev_at  = 0;
        for (int b = 1; b <= 4; b++) begin
            start_beat(8'(b));
            wait_ack(10, 1'b0, lat, at);
            check("t1_lat", lat, 1);
            if (b > 1) check("t1_period", at - prev_at, 2);
            prev_at = at;
        end
        bus.req = 1'b0;
        drain("t1");

        // T2: delay 5, ack_dly changed during WAIT must not matter
        ack_dly  = 5;
        rd_ready = 1'b0;
        c0       = ack_cnt;
        start_beat(8'h3C);
        step();
        ack_dly = 1;
        wait_ack(20, 1'b0, lat, at);
        check("t2_lat", lat + 1, 6);
        bus.req = 1'b0;
        check("t2_ack_one_cycle", bus.ack, 0);
        check("t2_ack_cnt", ack_cnt - c0, 1);
        check("t2_level", level, 1);
        check("t2_rd_valid", rd_valid, 1);
        check("t2_rd_data", rd_data, 8'h3C);
        drain("t2");

        // T3: backpressure when full, resume on pop
        ack_dly  = 0;
        rd_ready = 1'b0;
        c0       = ack_cnt;
        bad      = 0;
        for (int i = 0; i < 16; i++) begin
            start_beat(8'(8'h40 + i));
            wait_ack(10, 1'b0, lat, at);
            if (lat != 1) bad++;
        end
        check("t3_fill_lat", bad, 0);
        start_beat(8'h50);
        wait_ack(10, 1'b0, lat, at);
        check("t3_backpressure", lat, -1);
        check("t3_ack_cnt", ack_cnt - c0, 16);
        check("t3_level_full", level, 16);
        rd_ready = 1'b1;
        wait_ack(10, 1'b0, lat, at);
        check("t3_resume_lat", lat, 2);
        for (int i = 1; i <= 3; i++) begin
            start_beat(8'(8'h50 + i));
            wait_ack(10, 1'b0, lat, at);
            check("t3_tail_lat", lat, 1);
        end
        bus.req = 1'b0;
        drain("t3");

        // T4: simultaneous push/pop at level 3, 40 bytes through the wrap
        ack_dly  = 0;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_beat(8'(8'h80 + i));
            wait_ack(10, 1'b0, lat, at);
        end
        check("t4_level_pre", level, 3);
        bad = 0;
        for (int i = 3; i < 40; i++) begin
            start_beat(8'(8'h80 + i));
            wait_ack(10, 1'b1, lat, at);
            if (lat != 1 || level != 3) bad++;
        end
        check("t4_lvl_hold", bad, 0);
        check("t4_level", level, 3);
        bus.req = 1'b0;
        drain("t4");

        // T5: reset during WAIT drops the beat
        ack_dly  = 7;
        rd_ready = 1'b0;
        c0       = ack_cnt;
        start_beat(8'h5A);
        step();
        step();
        step();
        check("t5_no_ack_pre", bus.ack, 0);
        rst     = 1'b1;
        bus.req = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t5_ack_cnt", ack_cnt - c0, 0);
        check("t5_level", level, 0);
        check("t5_rd_valid", rd_valid, 0);
        ack_dly = 2;
        start_beat(8'h5A);
        wait_ack(20, 1'b0, lat, at);
        check("t5_reissue_lat", lat, 3);
        bus.req = 1'b0;
        check("t5_level_after", level, 1);
        check("t5_rd_data", rd_data, 8'h5A);
        drain("t5");

`ifdef IFRA_RCV_RAND_DLY_EN
        // T6: random delay bounded by ack_dly and repeatable after reset
        ack_dly = 7;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            start_beat(8'(8'hC0 + i));
            wait_ack(20, 1'b0, lat1[i], at);
            check("t6_range", (lat1[i] >= 1 && lat1[i] <= 8), 1);
        end
        bus.req = 1'b0;
        drain("t6a");
        do_reset();
        for (int i = 0; i < 4; i++) begin
            start_beat(8'(8'hC0 + i));
            wait_ack(20, 1'b0, lat2[i], at);
            check("t6_repeat", lat2[i], lat1[i]);
        end
        bus.req = 1'b0;
        drain("t6b");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifra_rcv.md
Name: ifra_rcv

Overview:
- Synthesizable responder (receive end) of the ifra req/ack byte interface; the ifra_mst transmitter drives req/dout, this block returns ack.
- Each accepted byte is pushed into an internal FIFO and presented on a show-ahead valid/ready read port for downstream logic.
- Ack latency is programmable per beat so the block can stand in for the behavioural ifra_slv in system sims and synthesised designs.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, >= 2.
- DLY_W, 4, width of ack_dly; max programmable delay is 2**DLY_W-1 cycles.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  transmitter request; held high with din stable until ack is seen.
- din  in  8  transmitter data byte.
- ack  out  1  one-cycle acknowledge; the beat is accepted on the edge where req && ack.
- ack_dly  in  DLY_W  extra cycles inserted before ack; sampled when a beat starts.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  downstream pop request.
- rd_data  out  8  FIFO head byte, valid when rd_valid.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: ack=0, rd_valid=0, level=0, rd_data=0, FSM in IDLE, delay counter=0, FIFO pointers=0.
- FSM states: IDLE, WAIT, ACK. ack is registered and is 1 only in ACK.
- IDLE, req=1 and level<DEPTH: load cnt=dly. If dly==0, go to ACK; otherwise go to WAIT.
- IDLE, req=1 and FIFO full: stay in IDLE with ack=0 (backpressure). Start when level drops below DEPTH.
- WAIT: cnt decrements each cycle. When cnt==1, go to ACK. If req drops in WAIT (protocol violation), return to IDLE with no push.
- ACK: ack=1 for exactly one cycle. On that edge, din is pushed to the FIFO (req is guaranteed high). Next state is IDLE.
- Latency: req first seen high at edge t gives ack high during cycle t+1+dly, so dly=0 means ack one cycle after req. The minimum beat period is 2 cycles; back-to-back beats alternate ACK and IDLE.
- Fullness check at IDLE is sufficient because the FIFO has only this writer. A push can never meet a full FIFO.
- FIFO is show-ahead: rd_data = mem[rd_ptr]. A pop occurs on rd_valid && rd_ready. rd_ready while empty is ignored.
- Simultaneous push and pop: level unchanged, both pointers advance. Pointers wrap modulo DEPTH using an extra MSB to tell full from empty.
- Reset mid-beat: the in-flight beat is dropped with no ack, and the FIFO is emptied. The transmitter must re-issue after reset.
- ack_dly changes while in WAIT have no effect on the current beat.

Optional Feature:
- Macro: IFRA_RCV_RAND_DLY_EN.
- With the macro: an 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - Per-beat dly = min(lfsr[DLY_W-1:0], ack_dly), so ack_dly becomes the maximum delay.
  - Reproduces ifra_slv random-delay behaviour deterministically.
- Without the macro: dly = ack_dly exactly, and no LFSR is present.

Decomposition:
- ifra_pkg:
  - IFRA_DATA_W = 8.
  - typedef enum logic [1:0] {IDLE, WAIT, ACK} ifra_rcv_st_e.
  - LFSR seed constant IFRA_LFSR_SEED = 8'hA5.
- Sub-module ifra_sync_fifo: parameters DEPTH and width. Ports push/din, pop/dout, empty/full/level, with sync active-high rst.
- ifra_rcv contains the FSM, delay counter, optional LFSR and one ifra_sync_fifo.

Test Plan:
- ack_dly=0, transmitter sends 1,2,3,4 back-to-back with rd_ready=1:
  - ack is high 1 cycle after each req edge, with period 2.
  - rd_data sequence is 1,2,3,4.
  - level returns to 0.
- ack_dly=5, single byte 8'h3C: ack rises exactly 6 cycles after req is sampled, lasts 1 cycle, level=1, rd_data=8'h3C.
- rd_ready=0, DEPTH=16, send 20 bytes with ack_dly=0:
  - 16 acks, then ack stays low and level=16.
  - Raise rd_ready: the remaining 4 are acked, and 20 bytes drain in order.
- Push and pop on the same edge with level=3: level stays 3, and the order is preserved across pointer wrap (send 40 bytes through DEPTH 16).
- Assert rst during WAIT (ack_dly=7, 3 cycles in):
  - ack never pulses, level=0, rd_valid=0.
  - The re-issued byte is accepted normally afterwards.
- IFRA_RCV_RAND_DLY_EN defined, ack_dly=7, send 4 bytes: each ack delay is in 0..7, and the delay sequence is identical across two runs after reset.
